// File: rtl/telemetry_deframer.sv
// telemetry_deframer: hunts for a sync byte in the UART byte stream, assembles an
// 8-byte checksummed payload into four 16-bit fields and drops stalled packets.
`timescale 1ns/1ps
module telemetry_deframer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 208_333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_busy,
    output logic [15:0] cpu_freq_mhz,
    output logic [15:0] disk_speed_mbps,
    output logic [15:0] memory_usage,
    output logic [15:0] temperature_c,
    output logic        compute_enable,
    output logic        checksum_error,
    output logic        timeout_error,
    output logic [15:0] packet_count,
    output logic        in_packet
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t        state, state_n;
    logic          prev_busy, strobe, timeout, good, bad;
    logic [2:0]    idx;
    logic [7:0]    sum;
    logic [TW-1:0] timer;
    logic [7:0]    shadow [8];

    // a completed byte is signalled by the falling edge of the receiver busy flag
    assign strobe    = prev_busy & ~rx_busy;
    assign in_packet = state != HUNT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HUNT;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        timeout = state != HUNT && !strobe && timer == T_LAST;
        good    = state == CHECK && strobe && rx_data == sum;
        bad     = state == CHECK && strobe && rx_data != sum;
        case (state)
            HUNT:    state_n = strobe && rx_data == SYNC_BYTE ? PAYLOAD : HUNT;
            PAYLOAD: state_n = strobe && idx == 3'd7 ? CHECK : PAYLOAD;
            CHECK:   state_n = strobe ? HUNT : CHECK;
            default: state_n = HUNT;
        endcase
        if (timeout) state_n = HUNT;
    end

    // idx and sum sit at zero while hunting, so a sync byte starts from a clean slate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_busy <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            timer     <= '0;
            shadow    <= '{default: '0};
        end else begin
            prev_busy <= rx_busy;
            timer     <= state == HUNT || strobe || timeout ? '0 : timer + TW'(1);
            if (state == HUNT || timeout) begin
                idx <= '0;
                sum <= '0;
            end else if (state == PAYLOAD && strobe) begin
                shadow[idx] <= rx_data;
                sum         <= sum + rx_data;
                idx         <= idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_freq_mhz    <= '0;
            disk_speed_mbps <= '0;
            memory_usage    <= '0;
            temperature_c   <= '0;
            compute_enable  <= 1'b0;
            checksum_error  <= 1'b0;
            timeout_error   <= 1'b0;
            packet_count    <= '0;
        end else begin
            compute_enable <= good;
            checksum_error <= bad;
            timeout_error  <= timeout;
            if (good) begin
                cpu_freq_mhz    <= {shadow[1], shadow[0]};
                disk_speed_mbps <= {shadow[3], shadow[2]};
                memory_usage    <= {shadow[5], shadow[4]};
                temperature_c   <= {shadow[7], shadow[6]};
                packet_count    <= packet_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_telemetry_deframer.sv
// tb_telemetry_deframer: directed and random byte streams scored against a
// packet-level reference model through an expected-event queue.
`timescale 1ns/1ps
module tb_telemetry_deframer;
    localparam int T = 100;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] f0, f1, f2, f3, cnt;
    } ev_t;

    logic        clk = 1'b0, rst = 1'b0, rx_busy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c, packet_count;
    logic        compute_enable, checksum_error, timeout_error, in_packet;

    telemetry_deframer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_busy(rx_busy),
        .cpu_freq_mhz(cpu_freq_mhz), .disk_speed_mbps(disk_speed_mbps),
        .memory_usage(memory_usage), .temperature_c(temperature_c),
        .compute_enable(compute_enable), .checksum_error(checksum_error),
        .timeout_error(timeout_error), .packet_count(packet_count),
        .in_packet(in_packet)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    ev_t expq[$];
    bit  in_pkt = 0, edgy = 0;
    logic [7:0]  pbuf[$];
    logic [15:0] m_f[4];
    logic [15:0] m_cnt = 0;
    int cyc = 0, last = 0;

    logic [7:0] p1[8] = '{8'h94, 8'h11, 8'hD0, 8'h07, 8'h00, 8'h40, 8'h46, 8'h00};
    logic [7:0] p2[8] = '{8'h48, 8'h0D, 8'h26, 8'h02, 8'h00, 8'h40, 8'h69, 8'h00};
    logic [7:0] p5[8] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every pulse cycle is one DUT event, matched in order against the model
    always @(negedge clk) begin
        ev_t a, e;
        if (rst && (compute_enable || checksum_error || timeout_error)) begin
            a.kind = (int'(compute_enable) + int'(checksum_error) + int'(timeout_error) != 1) ? 2'd0 :
                     compute_enable ? 2'd1 : checksum_error ? 2'd2 : 2'd3;
            a.f0 = cpu_freq_mhz; a.f1 = disk_speed_mbps; a.f2 = memory_usage; a.f3 = temperature_c;
            a.cnt = packet_count;
            e = expq.size() == 0 ? '0 : expq.pop_front();
            check("event", 128'(a), 128'(e));
        end
    end

    function automatic ev_t mk(input logic [1:0] k);
        return '{kind: k, f0: m_f[0], f1: m_f[1], f2: m_f[2], f3: m_f[3], cnt: m_cnt};
    endfunction

    // the packet is abandoned when more than T cycles separate two strobes inside it
    task automatic check_to(input int h);
        if (in_pkt && h - last > T) begin
            expq.push_back(mk(2'd3));
            in_pkt = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int s;
        if (!in_pkt) begin
            if (b == 8'hA5) begin
                in_pkt = 1;
                pbuf.delete();
            end
        end else begin
            pbuf.push_back(b);
            if (pbuf.size() == 9) begin
                s = 0;
                for (int i = 0; i < 8; i++) s += int'(pbuf[i]);
                if (s % 256 == int'(pbuf[8])) begin
                    m_cnt++;
                    for (int i = 0; i < 4; i++) m_f[i] = {pbuf[2*i+1], pbuf[2*i]};
                    expq.push_back(mk(2'd1));
                end else expq.push_back(mk(2'd2));
                in_pkt = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] b, input int bsy, input int gap);
        check_to(cyc + bsy);
        model_byte(b);
        rx_data = b;
        rx_busy = 1'b1;
        repeat (bsy) tick();
        rx_busy = 1'b0;
        last = cyc;
        check_to(cyc + gap + 1);
        repeat (gap) tick();
    endtask

    task automatic idle(input int n);
        check_to(cyc + n + 1);
        repeat (n) tick();
    endtask

    function automatic int rb();
        return $urandom_range(1, 4);
    endfunction

    function automatic int rg();
        int r;
        r = $urandom_range(0, 39);
        return (edgy && r == 0) ? T - 1 : (edgy && r == 1) ? T : $urandom_range(1, 5);
    endfunction

    task automatic send_frame(input logic [7:0] p[8], input logic [7:0] ck);
        send(8'hA5, rb(), rg());
        for (int i = 0; i < 8; i++) send(p[i], rb(), rg());
        send(ck, rb(), rg());
    endtask

    task automatic do_reset(input bit glitch);
        rst = 1'b0;
        rx_busy = glitch;
        rx_data = 8'hA5;
        repeat (3) tick();
        check("reset_outputs",
              128'({cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c, packet_count,
                    compute_enable, checksum_error, timeout_error, in_packet}), 128'(0));
        in_pkt = 0;
        expq.delete();
        for (int i = 0; i < 4; i++) m_f[i] = 16'h0;
        m_cnt = 0;
        rst = 1'b1;
        rx_busy = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_fields(input string name, input logic [79:0] exp);
        check(name, 128'({cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c, packet_count}),
              128'(exp));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish expected finish before 1.5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p[8];
        int s, k;
        for (int i = 0; i < 4; i++) m_f[i] = 16'h0;
        // busy falls right as reset releases: must not be taken as a sync byte
        do_reset(1'b1);

        send_frame(p1, 8'h02);
        idle(5);
        check_fields("pkt1", {16'd4500, 16'd2000, 16'd16384, 16'd70, 16'd1});

        send(8'h00, rb(), rg()); send(8'hFF, rb(), rg()); send(8'h13, rb(), rg());
        send_frame(p2, 8'h26);
        idle(5);
        check_fields("garbage_then_pkt2", {16'd3400, 16'd550, 16'd16384, 16'd105, 16'd2});

        send_frame(p1, 8'h03);
        idle(5);
        check_fields("bad_ck_holds", {16'd3400, 16'd550, 16'd16384, 16'd105, 16'd2});
        send_frame(p1, 8'h02);
        idle(5);
        check_fields("good_after_bad", {16'd4500, 16'd2000, 16'd16384, 16'd70, 16'd3});

        send(8'hA5, 2, 2); send(8'h94, 2, 2); send(8'h11, 2, 2);
        check("in_packet_high", 128'(in_packet), 128'(1));
        idle(T + 10);
        check("in_packet_after_timeout", 128'(in_packet), 128'(0));
        send_frame(p1, 8'h02);
        idle(5);
        check_fields("good_after_timeout", {16'd4500, 16'd2000, 16'd16384, 16'd70, 16'd4});

        // strobe period of exactly T survives, T+1 abandons the packet
        send(8'hA5, 2, T - 1); send(8'h94, 1, T); send(8'h11, 1, 3);
        check("in_packet_boundary", 128'(in_packet), 128'(0));

        send_frame(p5, 8'hA5);
        idle(5);
        check_fields("sync_in_payload", {16'h00A5, 16'd0, 16'd0, 16'd0, 16'd5});

        send(8'hA5, 2, 2);
        for (int i = 0; i < 4; i++) send(p1[i], 2, 2);
        do_reset(1'b0);
        send_frame(p1, 8'h02);
        idle(5);
        check_fields("after_mid_reset", {16'd4500, 16'd2000, 16'd16384, 16'd70, 16'd1});

        edgy = 1;
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) begin
                s = $urandom_range(0, 255);
                send(s == 8'hA5 ? 8'h00 : 8'(s), rb(), rg());
            end
            s = 0;
            for (int i = 0; i < 8; i++) begin
                p[i] = 8'($urandom_range(0, 255));
                s += int'(p[i]);
            end
            k = $urandom_range(0, 9);
            if (k < 2) send_frame(p, 8'(s + $urandom_range(1, 255)));
            else if (k == 2) begin
                send(8'hA5, rb(), rg());
                for (int i = 0; i < int'($urandom_range(0, 8)); i++) send(p[i], rb(), rg());
                idle(T + $urandom_range(0, 10));
            end else send_frame(p, 8'(s));
        end
        idle(T + 5);
        check("pending_events", 128'(expq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/telemetry_deframer.md
Name: telemetry_deframer

Overview:
Receive-side packet stage between the UART receiver and the scoring model. Detects completed bytes from the receiver's busy flag and hunts for a sync byte. It assembles an 8-byte little-endian telemetry payload, checks an additive checksum, and presents four 16-bit fields with a one-cycle compute_enable pulse. It also drops partial packets on an inter-byte timeout.

Parameters:
SYNC_BYTE, 8'hA5, start-of-packet marker.
TIMEOUT_CYCLES, 208_333, maximum clk cycles between byte strobes inside a packet (about 4 byte times at 50 MHz / 9600 baud). Must be at least 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rx_data  input  8  byte from the receiver; valid on the cycle rx_busy falls
rx_busy  input  1  receiver busy flag
cpu_freq_mhz  output  16  packet bytes 1:0
disk_speed_mbps  output  16  packet bytes 3:2
memory_usage  output  16  packet bytes 5:4
temperature_c  output  16  packet bytes 7:6
compute_enable  output  1  one-cycle pulse: new fields valid
checksum_error  output  1  one-cycle pulse: bad checksum
timeout_error  output  1  one-cycle pulse: packet abandoned
packet_count  output  16  good packets, wraps at 16'hFFFF->0
in_packet  output  1  high in PAYLOAD or CHECK

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; prev_busy 0; state HUNT.
  - Index, running sum, timeout counter and shadow bytes all 0.
- Byte strobe: strobe = prev_busy & ~rx_busy, where prev_busy is registered each cycle. rx_data is sampled on the strobe cycle. A falling edge right after reset (prev_busy=0) produces no strobe.
- Frame format: SYNC_BYTE, then payload bytes p0..p7, then CK. CK = (p0+...+p7) mod 256.
- HUNT:
  - Strobe with rx_data==SYNC_BYTE -> PAYLOAD; idx=0, sum=0, timer=0.
  - Any other byte is discarded silently; the state stays HUNT.
- PAYLOAD:
  - Each strobe stores rx_data into shadow[idx], sets sum=sum+rx_data (8-bit wrap), idx++.
  - The strobe that stores idx 7 moves to CHECK.
  - A byte equal to SYNC_BYTE is treated as data; there is no resync inside a packet.
- CHECK, on strobe:
  - rx_data==sum: at that same clock edge load all four output fields from shadow ({shadow[2k+1], shadow[2k]}), set compute_enable=1, packet_count++, go to HUNT.
  - rx_data!=sum: checksum_error=1, output fields unchanged, packet_count unchanged, go to HUNT.
- Latency: outputs and compute_enable become visible one clk after the checksum-byte strobe cycle. compute_enable is high for exactly one cycle.
- Output fields hold their last good values until the next good packet.
- Timeout (PAYLOAD/CHECK only):
  - timer clears on every strobe and increments otherwise.
  - When timer==TIMEOUT_CYCLES-1 with no strobe that cycle: timeout_error=1 for one cycle, go to HUNT, idx/sum cleared.
  - If a strobe and the timeout limit coincide, the strobe wins.
  - timer is held at 0 in HUNT.
- Error pulses and compute_enable are mutually exclusive and each lasts one cycle.
- Reset asserted mid-packet discards the partial packet and clears the output fields.
- Module size: roughly 150-250 lines. Recommended structure: three-state FSM, strobe detector, 3-bit idx, 8-bit sum, timeout counter of width $clog2(TIMEOUT_CYCLES), and 8x8 shadow array.

Test Plan:
1. Good packet: stream A5 94 11 D0 07 00 40 46 00 02 -> one compute_enable pulse; cpu=4500, disk=2000, mem=16384, temp=70; packet_count=1; no error pulses.
2. Garbage before sync, then a packet: stream 00 FF 13 then A5 48 0D 26 02 00 40 69 00 26 -> leading bytes ignored; cpu=3400, disk=550, mem=16384, temp=105; packet_count increments.
3. Bad checksum: packet 1 with CK=03 -> checksum_error pulses once; compute_enable stays 0; fields keep their prior values; packet_count unchanged. A following good packet is still accepted.
4. Timeout: TIMEOUT_CYCLES=100; send A5 94 11, then idle 100 cycles -> timeout_error pulses once, in_packet falls. Then send a full good packet -> accepted.
5. Sync value inside payload: A5 A5 00 00 00 00 00 00 00 A5 -> accepted; cpu=16'h00A5, other fields 0.
6. Mid-packet reset: assert rst=0 after 4 payload bytes -> all outputs 0, state HUNT. A subsequent full packet decodes correctly and packet_count=1.
